// File: rtl/bp_fe_gselect_idx_gen_if.sv
// bp_fe_gselect_idx_gen_if: fetch/predict/resolve/update bundle for the gselect index generator
// master = frontend driving fetches and resolutions, slave = index generator
interface bp_fe_gselect_idx_gen_if #(
  parameter int bht_idx_width_p = 9,
  parameter int vaddr_width_p   = 39
);
  logic                       fetch_v_i;
  logic [vaddr_width_p-1:0]   fetch_pc_i;
  logic                       fetch_ready_o;
  logic                       r_v_o;
  logic [bht_idx_width_p-1:0] idx_r_o;
  logic                       predict_i;
  logic                       res_v_i;
  logic                       res_taken_i;
  logic                       res_ready_o;
  logic                       w_v_o;
  logic [bht_idx_width_p-1:0] idx_w_o;
  logic                       correct_o;
  logic                       mispredict_o;
  modport master (
    output fetch_v_i, fetch_pc_i, predict_i, res_v_i, res_taken_i,
    input  fetch_ready_o, r_v_o, idx_r_o, res_ready_o, w_v_o, idx_w_o, correct_o, mispredict_o
  );
  modport slave (
    input  fetch_v_i, fetch_pc_i, predict_i, res_v_i, res_taken_i,
    output fetch_ready_o, r_v_o, idx_r_o, res_ready_o, w_v_o, idx_w_o, correct_o, mispredict_o
  );
endinterface

// File: rtl/bp_fe_gselect_idx_gen.sv
// bp_fe_gselect_idx_gen: gselect predictor index generator with speculative/committed history and in-flight queue
// ports: clk_i, reset_i (sync, active-high); bus (slave): fetch req/ready, read idx, predict_i,
//        in-order resolution req/ready, update idx/correct, mispredict flush pulse
module bp_fe_gselect_idx_gen #(
  parameter int bht_idx_width_p = 9,
  parameter int ghist_width_p   = 4,
  parameter int vaddr_width_p   = 39,
  parameter int inflight_els_p  = 8
) (
  input logic clk_i,
  input logic reset_i,
  bp_fe_gselect_idx_gen_if.slave bus
);
  localparam int pw_lp  = $clog2(inflight_els_p);
  localparam int cw_lp  = pw_lp + 1;
  localparam int pcw_lp = bht_idx_width_p - ghist_width_p;
  logic [ghist_width_p-1:0]   r_spec_ghr, r_commit_ghr, w_ghr, w_commit_ghr_n;
  logic                       r_pend_v;
  logic [bht_idx_width_p-1:0] r_pend_idx;
  logic [bht_idx_width_p-1:0] r_fifo_idx [inflight_els_p];
  logic [inflight_els_p-1:0]  r_fifo_pred;
  logic [pw_lp-1:0]           r_rd, r_wr;
  logic [cw_lp-1:0]           r_cnt;
  logic                       r_w_v, r_correct, r_mispred;
  logic [bht_idx_width_p-1:0] r_idx_w;
  logic                       w_fetch, w_res, w_flush, w_push;
  logic                       w_unused_pc;
  assign w_unused_pc = ^{bus.fetch_pc_i[vaddr_width_p-1:pcw_lp+2], bus.fetch_pc_i[1:0]};
  always_comb begin
    // bypass the pending prediction so back-to-back fetches see it
    w_ghr             = r_pend_v ? {r_spec_ghr[ghist_width_p-2:0], bus.predict_i} : r_spec_ghr;
    w_commit_ghr_n    = {r_commit_ghr[ghist_width_p-2:0], bus.res_taken_i};
    bus.res_ready_o   = ~reset_i & (r_cnt != '0);
    w_res             = bus.res_v_i & bus.res_ready_o;
    w_flush           = w_res & (r_fifo_pred[r_rd] != bus.res_taken_i);
    w_push            = r_pend_v & ~w_flush;
    // pending entry reserves a slot; a pop frees one only from the next cycle
    bus.fetch_ready_o = ~reset_i & ~w_flush & ((r_cnt + cw_lp'(r_pend_v)) < cw_lp'(inflight_els_p));
    w_fetch           = bus.fetch_v_i & bus.fetch_ready_o;
    bus.r_v_o         = w_fetch;
    bus.idx_r_o       = {bus.fetch_pc_i[pcw_lp+1:2], w_ghr};
    bus.w_v_o         = r_w_v;
    bus.idx_w_o       = r_idx_w;
    bus.correct_o     = r_correct;
    bus.mispredict_o  = r_mispred;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_spec_ghr   <= '0;
      r_commit_ghr <= '0;
      r_pend_v     <= 1'b0;
      r_pend_idx   <= '0;
      r_rd         <= '0;
      r_wr         <= '0;
      r_cnt        <= '0;
      r_w_v        <= 1'b0;
      r_mispred    <= 1'b0;
      r_correct    <= 1'b0;
      r_idx_w      <= '0;
    end else begin
      r_w_v     <= w_res;
      r_mispred <= w_flush;
      r_pend_v  <= w_fetch;
      if (w_fetch) r_pend_idx <= bus.idx_r_o;
      if (w_res) begin
        r_idx_w      <= r_fifo_idx[r_rd];
        r_correct    <= ~w_flush;
        r_commit_ghr <= w_commit_ghr_n;
      end
      if (w_flush) begin
        r_spec_ghr <= w_commit_ghr_n;
        r_rd       <= '0;
        r_wr       <= '0;
        r_cnt      <= '0;
      end else begin
        if (w_push) begin
          r_spec_ghr <= {r_spec_ghr[ghist_width_p-2:0], bus.predict_i};
          r_wr       <= r_wr + pw_lp'(1);
        end
        if (w_res) r_rd <= r_rd + pw_lp'(1);
        r_cnt <= r_cnt + cw_lp'(w_push) - cw_lp'(w_res);
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_idx[r_wr]  <= r_pend_idx;
      r_fifo_pred[r_wr] <= bus.predict_i;
    end
  end
endmodule

// File: doc/bp_fe_gselect_idx_gen.md
BP_FE_GSELECT_IDX_GEN -- requirements
Module: bp_fe_gselect_idx_gen

Interface
REQ-001 Parameter: bht_idx_width_p, 9, predictor table index width.
REQ-002 Parameter: ghist_width_p, 4, global history bits in index (< bht_idx_width_p).
REQ-003 Parameter: vaddr_width_p, 39, fetch PC width.
REQ-004 Parameter: inflight_els_p, 8, max unresolved branches (power of 2, >= 2).
REQ-005 Port: clk_i  input  1  sole clock; all state updates on rising edge.
REQ-006 Port: reset_i  input  1  synchronous, active-high reset.
REQ-007 Port: fetch_v_i  input  1  branch fetch request valid.
REQ-008 Port: fetch_pc_i  input  vaddr_width_p  branch PC.
REQ-009 Port: fetch_ready_o  output  1  fetch accepted when fetch_v_i & fetch_ready_o.
REQ-010 Port: r_v_o  output  1  predictor read valid.
REQ-011 Port: idx_r_o  output  bht_idx_width_p  predictor read index.
REQ-012 Port: predict_i  input  1  predictor taken bit, valid the cycle after r_v_o.
REQ-013 Port: res_v_i  input  1  in-order resolution of oldest in-flight branch.
REQ-014 Port: res_taken_i  input  1  actual direction.
REQ-015 Port: res_ready_o  output  1  in-flight queue non-empty.
REQ-016 Port: w_v_o  output  1  predictor update valid.
REQ-017 Port: idx_w_o  output  bht_idx_width_p  predictor update index.
REQ-018 Port: correct_o  output  1  1 = stored prediction matched actual direction.
REQ-019 Port: mispredict_o  output  1  one-cycle flush pulse.

Function
REQ-020 Index SHALL be {fetch_pc_i[bht_idx_width_p-ghist_width_p+1:2], spec_ghr}, history in LSBs.
REQ-021 r_v_o = accepted fetch, idx_r_o driven combinationally in the same cycle (zero latency).
REQ-022 Accepted fetch SHALL set a one-entry pending stage holding idx; next cycle predict_i is sampled, spec_ghr <= {spec_ghr[ghist_width_p-2:0], predict_i}, and {idx, predict_i} pushed to the in-flight FIFO.
REQ-023 Back-to-back fetches SHALL be accepted every cycle; the second fetch's idx uses spec_ghr including the first prediction via bypass of predict_i.
REQ-024 fetch_ready_o = ~reset_i & ~flush & (fifo_count + pending < inflight_els_p).
REQ-025 Resolution accepted when res_v_i & res_ready_o; res_v_i on empty FIFO SHALL be ignored (no state change, no output).
REQ-026 On accepted resolution: pop head; commit_ghr <= {commit_ghr[ghist_width_p-2:0], res_taken_i}; next cycle w_v_o=1, idx_w_o=head idx, correct_o=(head pred == res_taken_i).
REQ-027 flush = accepted resolution with head pred != res_taken_i; mispredict_o SHALL be registered, asserting the cycle after flush.
REQ-028 On flush: FIFO emptied, pending stage discarded (no push, no spec_ghr shift), spec_ghr <= updated commit_ghr value, any fetch that cycle not accepted.
REQ-029 Simultaneous push and non-flush pop SHALL keep count unchanged; FIFO pointers wrap modulo inflight_els_p.
REQ-030 w_v_o, mispredict_o SHALL be single-cycle pulses; idx_w_o/correct_o hold last value otherwise.

Reset
REQ-031 Reset SHALL clear spec_ghr, commit_ghr, FIFO pointers/count, pending stage; w_v_o, mispredict_o, r_v_o, fetch_ready_o, res_ready_o = 0 during reset.
REQ-032 Reset mid-operation SHALL drop all in-flight entries with no w_v_o emitted; fetch_ready_o = 1 first cycle after reset deasserts.

Verification
REQ-033 Reset, fetch pc=0x40 -> same cycle r_v_o=1, idx_r_o=9'h100.
REQ-034 predict_i=1 for REQ-033, fetch pc=0x40 next cycle -> idx_r_o=9'h101; res taken=1 -> next cycle w_v_o=1, idx_w_o=9'h100, correct_o=1.
REQ-035 Three fetches predicted 1,1,1; resolve oldest taken=0 -> w_v_o=1, correct_o=0, mispredict_o=1, res_ready_o=0, next fetch pc=0x40 gives idx_r_o=9'h100.
REQ-036 Eight fetches unresolved -> fetch_ready_o=0; resolve taken with fetch_v_i=1 same cycle -> fetch accepted next cycle, count stays 8.
REQ-037 res_v_i=1 with empty FIFO -> no w_v_o, GHRs unchanged.
REQ-038 Reset asserted with 5 in flight -> no w_v_o, res_ready_o=0, next fetch idx history bits 0.
